// File: rtl/md_iter_ctrl.sv
// Iteration scheduler: loads the position caches, then loops PE -> MU until the programmed count.
// Optional watchdog on PE_RUN/MU_RUN enabled by defining MD_ITER_CTRL_TIMEOUT_EN.
module md_iter_ctrl #(
  parameter int NUM_CELLS         = 8,
  parameter int NUM_INIT_STEPS    = 2,
  parameter int PARTICLE_ID_WIDTH = 8,
  parameter int INIT_DEPTH        = 64,
  parameter int ITER_WIDTH        = 16,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [ITER_WIDTH-1:0]        i_num_iters,
  input  logic                         i_init_valid,
  output logic                         o_init_ready,
  output logic [PARTICLE_ID_WIDTH-1:0] o_init_wr_addr,
  output logic [NUM_INIT_STEPS-1:0]    o_init_wr_en,
  input  logic                         i_PE_done,
  input  logic [NUM_CELLS-1:0]         i_all_dirty,
  output logic                         o_PE_start,
  output logic                         o_MU_start,
  output logic                         o_MU_working,
  output logic                         o_iter_target_reached,
  output logic [ITER_WIDTH-1:0]        o_iter_cnt,
  output logic                         o_busy,
  output logic                         o_timeout,
  output logic [2:0]                   o_state
);

  localparam int PASS_W = (NUM_INIT_STEPS > 1) ? $clog2(NUM_INIT_STEPS) : 1;
  localparam logic [PARTICLE_ID_WIDTH-1:0] LAST_ADDR = PARTICLE_ID_WIDTH'(INIT_DEPTH - 1);
  localparam logic [PASS_W-1:0]            LAST_PASS = PASS_W'(NUM_INIT_STEPS - 1);

  generate
    if (INIT_DEPTH < 1 || INIT_DEPTH > (1 << PARTICLE_ID_WIDTH) ||
        NUM_INIT_STEPS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("md_iter_ctrl: invalid parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    PE_START = 3'd2,
    PE_RUN   = 3'd3,
    MU_START = 3'd4,
    MU_RUN   = 3'd5,
    CHECK    = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t                         state_reg;
  logic [ITER_WIDTH-1:0]          iter_cnt_reg;
  logic [ITER_WIDTH-1:0]          target_reg;
  logic [ITER_WIDTH-1:0]          iter_cnt_inc;
  logic [PARTICLE_ID_WIDTH-1:0]   addr_reg;
  logic [PARTICLE_ID_WIDTH-1:0]   wr_addr_reg;
  logic [PASS_W-1:0]              pass_reg;
  logic [NUM_INIT_STEPS-1:0]      wr_en_next;
  logic [NUM_INIT_STEPS-1:0]      wr_en_reg;
  logic                           init_ready_reg;
  logic                           init_accept;
  logic                           pe_start_reg;
  logic                           mu_start_reg;
  logic                           mu_working_reg;
  logic                           reached_reg;
  logic                           busy_reg;
  logic                           timeout_reg;
  logic [2:0]                     state_out_reg;

`ifdef MD_ITER_CTRL_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer_reg;
  logic               timer_hit;
  assign timer_hit = (timer_reg == TIMER_LAST);
`endif

  // init_ready_reg is set on INIT entry and cleared on exit, so it doubles as the INIT flag
  assign init_accept  = init_ready_reg & i_init_valid;
  assign iter_cnt_inc = iter_cnt_reg + ITER_WIDTH'(1);

  generate
    for (genvar gi = 0; gi < NUM_INIT_STEPS; gi++) begin : g_wr_en
      assign wr_en_next[gi] = init_accept && (pass_reg == PASS_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      iter_cnt_reg   <= '0;
      target_reg     <= '0;
      addr_reg       <= '0;
      wr_addr_reg    <= '0;
      pass_reg       <= '0;
      wr_en_reg      <= '0;
      init_ready_reg <= 1'b0;
      pe_start_reg   <= 1'b0;
      mu_start_reg   <= 1'b0;
      mu_working_reg <= 1'b0;
      reached_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      state_out_reg  <= 3'd0;
`ifdef MD_ITER_CTRL_TIMEOUT_EN
      timer_reg      <= '0;
`endif
    end else begin
      // Status outputs trail the state register by one cycle
      pe_start_reg   <= (state_reg == PE_START);
      mu_start_reg   <= (state_reg == MU_START);
      mu_working_reg <= (state_reg == MU_RUN);
      busy_reg       <= (state_reg != IDLE) && (state_reg != DONE);
      reached_reg    <= (state_reg == DONE) && !timeout_reg;
      state_out_reg  <= state_reg;
      wr_en_reg      <= wr_en_next;
      if (init_accept) begin
        wr_addr_reg <= addr_reg;
      end
`ifdef MD_ITER_CTRL_TIMEOUT_EN
      timer_reg <= '0;
`endif

      case (state_reg)
        IDLE, DONE: begin
          if (i_start) begin
            state_reg      <= INIT;
            init_ready_reg <= 1'b1;
            iter_cnt_reg   <= '0;
            pass_reg       <= '0;
            addr_reg       <= '0;
            timeout_reg    <= 1'b0;
            target_reg     <= i_num_iters;
          end
        end
        INIT: begin
          if (init_accept) begin
            if (addr_reg == LAST_ADDR) begin
              addr_reg <= '0;
              if (pass_reg == LAST_PASS) begin
                init_ready_reg <= 1'b0;
                state_reg      <= (target_reg == '0) ? DONE : PE_START;
              end else begin
                pass_reg <= pass_reg + PASS_W'(1);
              end
            end else begin
              addr_reg <= addr_reg + PARTICLE_ID_WIDTH'(1);
            end
          end
        end
        PE_START: state_reg <= PE_RUN;
        PE_RUN: begin
          if (i_PE_done) begin
            state_reg <= MU_START;
          end
`ifdef MD_ITER_CTRL_TIMEOUT_EN
          else if (timer_hit) begin
            state_reg   <= DONE;
            timeout_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
`endif
        end
        MU_START: state_reg <= MU_RUN;
        MU_RUN: begin
          if (&i_all_dirty) begin
            state_reg <= CHECK;
          end
`ifdef MD_ITER_CTRL_TIMEOUT_EN
          else if (timer_hit) begin
            state_reg   <= DONE;
            timeout_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
`endif
        end
        CHECK: begin
          iter_cnt_reg <= iter_cnt_inc;
          state_reg    <= (iter_cnt_inc == target_reg) ? DONE : PE_START;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_init_ready          = init_ready_reg;
  assign o_init_wr_addr        = wr_addr_reg;
  assign o_init_wr_en          = wr_en_reg;
  assign o_PE_start            = pe_start_reg;
  assign o_MU_start            = mu_start_reg;
  assign o_MU_working          = mu_working_reg;
  assign o_iter_target_reached = reached_reg;
  assign o_iter_cnt            = iter_cnt_reg;
  assign o_busy                = busy_reg;
  assign o_timeout             = timeout_reg;
  assign o_state               = state_out_reg;

endmodule

// File: tb/tb_md_iter_ctrl.sv
// Self-checking bench for md_iter_ctrl: per-cycle model comparison plus literal expectations.
module tb_md_iter_ctrl;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_num_iters = '0;
  logic        i_init_valid = 1'b0;
  logic        i_PE_done = 1'b0;
  logic [7:0]  i_all_dirty = '0;
  logic        o_init_ready;
  logic [7:0]  o_init_wr_addr;
  logic [1:0]  o_init_wr_en;
  logic        o_PE_start, o_MU_start, o_MU_working, o_iter_target_reached;
  logic [15:0] o_iter_cnt;
  logic        o_busy, o_timeout;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  md_iter_ctrl #(
    .NUM_CELLS(8), .NUM_INIT_STEPS(S), .PARTICLE_ID_WIDTH(8),
    .INIT_DEPTH(D), .ITER_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_iters(i_num_iters),
    .i_init_valid(i_init_valid), .o_init_ready(o_init_ready),
    .o_init_wr_addr(o_init_wr_addr), .o_init_wr_en(o_init_wr_en),
    .i_PE_done(i_PE_done), .i_all_dirty(i_all_dirty),
    .o_PE_start(o_PE_start), .o_MU_start(o_MU_start), .o_MU_working(o_MU_working),
    .o_iter_target_reached(o_iter_target_reached), .o_iter_cnt(o_iter_cnt),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_state(o_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase follows the documented state rules; init progress is a flat write count
  int          m_phase, m_writes, m_iters, m_target, m_wait;
  bit          m_to;
  logic [2:0]  e_state;
  logic        e_ready, e_pe, e_mu, e_muw, e_reach, e_busy, e_to;
  logic [1:0]  e_wr_en;
  logic [7:0]  e_wr_addr;
  logic [15:0] e_cnt;

  task automatic model_reset();
    m_phase = 0; m_writes = 0; m_iters = 0; m_target = 0; m_wait = 0; m_to = 0;
    e_state = 0; e_ready = 0; e_pe = 0; e_mu = 0; e_muw = 0; e_reach = 0;
    e_busy = 0; e_to = 0; e_wr_en = 0; e_wr_addr = 0; e_cnt = 0;
  endtask

  task automatic model_step();
    int prev;
    prev    = m_phase;
    e_state = 3'(prev);
    e_pe    = (prev == 2);
    e_mu    = (prev == 4);
    e_muw   = (prev == 5);
    e_busy  = (prev != 0) && (prev != 7);
    e_reach = (prev == 7) && !m_to;
    e_wr_en = 2'b00;
    case (prev)
      0, 7: if (i_start) begin
        m_phase = 1; m_writes = 0; m_iters = 0; m_to = 0; m_target = int'(i_num_iters);
      end
      1: if (i_init_valid) begin
        e_wr_en   = 2'(1 << (m_writes / D));
        e_wr_addr = 8'(m_writes % D);
        m_writes++;
        if (m_writes == D * S) m_phase = (m_target == 0) ? 7 : 2;
      end
      2: m_phase = 3;
      3: if (i_PE_done) m_phase = 4;
      4: m_phase = 5;
      5: if (&i_all_dirty) m_phase = 6;
      6: begin
        m_iters++;
        m_phase = (m_iters == m_target) ? 7 : 2;
      end
      default: m_phase = 0;
    endcase
`ifdef MD_ITER_CTRL_TIMEOUT_EN
    if ((prev == 3 || prev == 5) && m_phase == prev) begin
      m_wait++;
      if (m_wait == TO) begin
        m_phase = 7;
        m_to = 1;
        m_wait = 0;
      end
    end else begin
      m_wait = 0;
    end
`endif
    e_ready = (m_phase == 1);
    e_cnt   = 16'(m_iters);
    e_to    = m_to;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("state", 32'(o_state), 32'(e_state));
      chk("init_ready", 32'(o_init_ready), 32'(e_ready));
      chk("wr_en", 32'(o_init_wr_en), 32'(e_wr_en));
      chk("wr_addr", 32'(o_init_wr_addr), 32'(e_wr_addr));
      chk("pe_start", 32'(o_PE_start), 32'(e_pe));
      chk("mu_start", 32'(o_MU_start), 32'(e_mu));
      chk("mu_working", 32'(o_MU_working), 32'(e_muw));
      chk("target_reached", 32'(o_iter_target_reached), 32'(e_reach));
      chk("iter_cnt", 32'(o_iter_cnt), 32'(e_cnt));
      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("timeout", 32'(o_timeout), 32'(e_to));
    end
  end

  // Transaction log used by the literal checks
  int          wr_addr_q[$];
  int          wr_en_q[$];
  int          iter_q[$];
  int          pe_cnt, mu_cnt, pe_first_cyc, last_acc_cyc;
  logic [15:0] last_iter;

  task automatic clear_log();
    wr_addr_q.delete(); wr_en_q.delete(); iter_q.delete();
    pe_cnt = 0; mu_cnt = 0; pe_first_cyc = -1; last_acc_cyc = -1;
    last_iter = o_iter_cnt;
  endtask

  initial begin
    clear_log();
    forever begin
      @(negedge clk);
      if (rst) begin
        if (o_init_ready && i_init_valid) last_acc_cyc = cyc;
        if (o_init_wr_en != 0) begin
          wr_addr_q.push_back(int'(o_init_wr_addr));
          wr_en_q.push_back(int'(o_init_wr_en));
          $display("init write addr=%0d en=%b", o_init_wr_addr, o_init_wr_en);
        end
        if (o_PE_start) begin
          if (pe_cnt == 0) pe_first_cyc = cyc;
          pe_cnt++;
        end
        if (o_MU_start) mu_cnt++;
        if (o_iter_cnt != last_iter) begin
          iter_q.push_back(int'(o_iter_cnt));
          $display("iteration count -> %0d", o_iter_cnt);
          last_iter = o_iter_cnt;
        end
      end
    end
  end

  // PE and MU responders: done 10 cycles after each PE pulse, all-dirty 20 cycles after each MU pulse
  bit pe_resp_en = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (o_PE_start && pe_resp_en) begin
        repeat (10) @(posedge clk);
        #1 i_PE_done = 1'b1;
        @(posedge clk);
        #1 i_PE_done = 1'b0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (o_MU_start) begin
        repeat (20) @(posedge clk);
        #1 i_all_dirty = 8'hFF;
        @(posedge clk);
        #1 i_all_dirty = 8'h00;
      end
    end
  end

  function automatic logic [31:0] probe(input int which);
    case (which)
      0:       return 32'(o_state);
      1:       return 32'(o_iter_target_reached);
      2:       return 32'(o_iter_cnt);
      3:       return 32'(o_MU_working);
      default: return 32'(o_timeout);
    endcase
  endfunction

  task automatic wait_until(input int which, input logic [31:0] val, input int budget, input string name);
    int n;
    n = 0;
    while (probe(which) != val && n < budget) begin
      tick();
      n++;
    end
    chk(name, probe(which), val);
  endtask

  task automatic start_run(input logic [15:0] iters);
    i_num_iters = iters;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    int exp_addr[8];
    int exp_en[8];
    exp_addr = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_en   = '{1, 1, 1, 1, 2, 2, 2, 2};

    // Reset state
    i_init_valid = 1'b1;
    repeat (3) tick();
    chk("reset_state", 32'(o_state), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_iter_cnt", 32'(o_iter_cnt), 0);
    chk("reset_init_ready", 32'(o_init_ready), 0);
    rst = 1'b1;
    tick();

    // Run A: 3 iterations, with a 5-cycle init stall at address 2
    clear_log();
    start_run(16'd3);
    tick();
    tick();
    i_init_valid = 1'b0;
    repeat (2) tick();
    chk("stall_wr_en", 32'(o_init_wr_en), 0);
    chk("stall_ready", 32'(o_init_ready), 1);
    repeat (3) tick();
    i_init_valid = 1'b1;
    wait_until(1, 1, 2000, "run3_reached");
    chk("run3_write_count", 32'(wr_addr_q.size()), 8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      chk("run3_wr_addr_seq", 32'(wr_addr_q[i]), 32'(exp_addr[i]));
      chk("run3_wr_en_seq", 32'(wr_en_q[i]), 32'(exp_en[i]));
    end
    chk("run3_pe_after_last_write", 32'(pe_first_cyc - last_acc_cyc), 2);
    chk("run3_pe_pulses", 32'(pe_cnt), 3);
    chk("run3_mu_pulses", 32'(mu_cnt), 3);
    chk("run3_iter_steps", 32'(iter_q.size()), 3);
    for (int i = 0; i < 3 && i < iter_q.size(); i++)
      chk("run3_iter_value", 32'(iter_q[i]), 32'(i + 1));
    chk("run3_final_cnt", 32'(o_iter_cnt), 3);
    chk("run3_done_state", 32'(o_state), 7);

    // Run B: zero target goes straight to DONE after init
    clear_log();
    start_run(16'd0);
    tick();
    wait_until(1, 1, 200, "zero_reached");
    chk("zero_iter_cnt", 32'(o_iter_cnt), 0);
    chk("zero_pe_pulses", 32'(pe_cnt), 0);
    chk("zero_mu_pulses", 32'(mu_cnt), 0);
    chk("zero_write_count", 32'(wr_addr_q.size()), 8);

    // Run C: ignored start while busy, then asynchronous reset during MU_RUN
    start_run(16'd5);
    wait_until(0, 3, 200, "c_pe_run");
    i_num_iters = 16'd1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    chk("busy_start_state", 32'(o_state), 3);
    chk("busy_start_busy", 32'(o_busy), 1);
    wait_until(2, 1, 200, "c_iter1");
    wait_until(3, 1, 200, "c_mu_working");
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", 32'(o_state), 0);
    chk("async_rst_mu_working", 32'(o_MU_working), 0);
    chk("async_rst_iter_cnt", 32'(o_iter_cnt), 0);
    chk("async_rst_busy", 32'(o_busy), 0);
    tick();
    tick();
    rst = 1'b1;
    repeat (30) tick();

    // Run D: single iteration after reset
    clear_log();
    start_run(16'd1);
    wait_until(1, 1, 300, "one_reached");
    chk("one_iter_cnt", 32'(o_iter_cnt), 1);
    chk("one_pe_pulses", 32'(pe_cnt), 1);

`ifdef MD_ITER_CTRL_TIMEOUT_EN
    // Watchdog: PE never completes
    pe_resp_en = 1'b0;
    start_run(16'd2);
    wait_until(4, 1, 400, "to_flag");
    tick();
    chk("to_state", 32'(o_state), 7);
    chk("to_reached", 32'(o_iter_target_reached), 0);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
